// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, inter-stage bus widths and layouts,
// mem_control bit positions, and the multiplier FSM state encoding.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ID_EXE_W    = 143;
    localparam int unsigned EXE_MEM_W   = 106;
    localparam int unsigned MEM_WB_W    = 70;
    localparam int unsigned MUL_ITER    = 32;
    localparam int unsigned MUL_CNT_W   = $clog2(MUL_ITER);

    // ALU op codes (12-15 are reserved and produce zero)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // mem_control = {load, store, word, lb_sign}
    localparam int unsigned MEMC_LOAD    = 3;
    localparam int unsigned MEMC_STORE   = 2;
    localparam int unsigned MEMC_WORD    = 1;
    localparam int unsigned MEMC_LB_SIGN = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            is_mul;
        logic [XLEN-1:0] alu_operand1;
        logic [XLEN-1:0] alu_operand2;
        logic [3:0]      mem_control;
        logic [XLEN-1:0] store_data;
        logic            rf_wen;
        logic [4:0]      rf_wdest;
        logic [XLEN-1:0] pc;
    } id_exe_bus_t;

    typedef struct packed {
        logic [3:0]      mem_control;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] exe_result;
        logic            rf_wen;
        logic [4:0]      rf_wdest;
        logic [XLEN-1:0] pc;
    } exe_mem_bus_t;

endpackage

// File: rtl/exe_multiplier.sv
// Iterative shift-add 32x32 multiplier, low product word only.
// Ports: clk, rst (sync, active-high); start loads a/b when idle; abort
// returns to idle from BUSY or DONE; busy/done decode the state; product
// is the running accumulator, final once done is high.
module exe_multiplier
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(MUL_ITER - 1);

    mul_state_t            state_q, state_d;
    logic [XLEN-1:0]       mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic [XLEN-1:0]       prod_q, prod_d;
    logic [MUL_CNT_W-1:0]  count_q, count_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
        end
    end

    // Next state and one shift-add step per BUSY cycle
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    prod_d   = '0;
                    count_d  = '0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (abort) begin
                    state_d = MUL_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + MUL_CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = MUL_DONE;
                    end
                end
            end
            MUL_DONE: begin
                // Held until the controller drops valid; no restart from here
                if (abort) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = prod_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU plus iterative multiplier, packs EXE_MEM bus.
// Ports: clk, rst (sync, active-high); EXE_valid level enable from controller;
// ID_EXE_bus_r registered decode bus; EXE_over stage complete; EXE_MEM_bus
// to memory stage; EXE_pc pc passthrough; mul_busy multiplier iterating.
module exe_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXE_valid,
    input  logic [ID_EXE_W-1:0]  ID_EXE_bus_r,
    output logic                 EXE_over,
    output logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic [XLEN-1:0]      EXE_pc,
    output logic                 mul_busy
);

    id_exe_bus_t     id_bus;
    exe_mem_bus_t    mem_bus;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] op1, op2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] mul_product;
    logic            mul_done;

    assign id_bus = id_exe_bus_t'(ID_EXE_bus_r);
    assign op1    = id_bus.alu_operand1;
    assign op2    = id_bus.alu_operand2;
    assign shamt  = op1[4:0];

    exe_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (EXE_valid & id_bus.is_mul),
        .abort   (~EXE_valid),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ALU; shifts move operand2 by operand1[4:0]
    always_comb begin
        alu_result = '0;
        case (id_bus.alu_op)
            ALU_ADD:  alu_result = op1 + op2;
            ALU_SUB:  alu_result = op1 - op2;
            ALU_SLT:  alu_result = XLEN'($signed(op1) < $signed(op2));
            ALU_SLTU: alu_result = XLEN'(op1 < op2);
            ALU_AND:  alu_result = op1 & op2;
            ALU_OR:   alu_result = op1 | op2;
            ALU_XOR:  alu_result = op1 ^ op2;
            ALU_NOR:  alu_result = ~(op1 | op2);
            ALU_SLL:  alu_result = op2 << shamt;
            ALU_SRL:  alu_result = op2 >> shamt;
            ALU_SRA:  alu_result = XLEN'($signed(op2) >>> shamt);
            ALU_LUI:  alu_result = {op2[15:0], 16'd0};
            default:  alu_result = '0;
        endcase
    end

    assign EXE_over = id_bus.is_mul ? (EXE_valid & mul_done) : EXE_valid;

    always_comb begin
        mem_bus.mem_control = id_bus.mem_control;
        mem_bus.store_data  = id_bus.store_data;
        mem_bus.exe_result  = id_bus.is_mul ? mul_product : alu_result;
        mem_bus.rf_wen      = id_bus.rf_wen;
        mem_bus.rf_wdest    = id_bus.rf_wdest;
        mem_bus.pc          = id_bus.pc;
    end

    assign EXE_MEM_bus = EXE_MEM_W'(mem_bus);
    assign EXE_pc      = id_bus.pc;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the multi-cycle CPU. Sits between decode and the memory-access stage.
- Consumes the registered decode bus and performs the ALU operation, or an iterative 32x32 multiply (low word only).
- Produces the 106-bit EXE_MEM bus that feeds the memory-access stage.
- Single-cycle ops complete combinationally. MUL completes after a fixed 32-cycle iteration, handshaken to the stage controller via EXE_over.

Parameters:
- MUL_ITER, 32, multiplier iterations (one operand bit per cycle); fixed for 32-bit datapath.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- EXE_valid  in  1  stage enable from controller; level, held until EXE_over seen
- ID_EXE_bus_r  in  143  {alu_op[3:0], is_mul, alu_operand1[31:0], alu_operand2[31:0], mem_control[3:0], store_data[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}
- EXE_over  out  1  stage complete
- EXE_MEM_bus  out  106  {mem_control[3:0], store_data[31:0], exe_result[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}
- EXE_pc  out  32  pc field passthrough
- mul_busy  out  1  high while multiplier state is BUSY

Behaviour:
- The clock is clk. Reset rst is synchronous and active-high.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR
  - 8 SLL, 9 SRL, 10 SRA: operand2 shifted by operand1[4:0]
  - 11 LUI: {operand2[15:0],16'd0}
  - 12-15 yield 0
- ADD/SUB wrap modulo 2^32; no overflow trap. SLT/SLTU results are zero-extended 1 bit.
- Non-MUL (is_mul=0):
  - exe_result = ALU result, combinational.
  - EXE_over = EXE_valid, same cycle.
  - Multiplier FSM stays IDLE.
- MUL (is_mul=1): alu_op is ignored and exe_result = product low 32 bits. Signed and unsigned give the same low word.
- FSM states IDLE, BUSY, DONE; reset -> IDLE.
  - IDLE: if EXE_valid & is_mul at edge N:
    - load multiplicand = operand1, multiplier = operand2, product = 0, count = 0.
    - Next state BUSY.
  - BUSY: each cycle:
    - if multiplier[0], product += multiplicand (mod 2^32).
    - multiplicand <<= 1; multiplier >>= 1; count++.
    - After count reaches MUL_ITER-1 (32nd BUSY cycle), go to DONE.
  - DONE: EXE_over = EXE_valid. Stays in DONE while EXE_valid=1; returns to IDLE the cycle after EXE_valid=0.
  - Latency: validated in IDLE at cycle N -> BUSY cycles N+1..N+32 -> EXE_over first high at N+33.
- During IDLE/BUSY with is_mul=1, EXE_over=0.
- exe_result during MUL is the product register. It is only guaranteed valid in DONE.
- EXE_valid falling during BUSY: abort and return to IDLE next cycle. Product contents are undefined to consumers.
- rst mid-operation (any state): next cycle IDLE, count=0, product=0, mul_busy=0.
- Reset values: mul_busy=0, EXE_over=EXE_valid&~is_mul (0 with EXE_valid=0), internal registers 0.
- Passthrough fields (mem_control, store_data, rf_wen, rf_wdest, pc) are combinational from ID_EXE_bus_r. The controller holds ID_EXE_bus_r stable while EXE_valid=1.
- A new MUL cannot start in DONE. It starts only after a return to IDLE.

Decomposition:
- Shared package (cpu_pkg):
  - ALU op code constants.
  - Bus widths: ID_EXE 143, EXE_MEM 106, MEM_WB 70.
  - mem_control bit positions {load, store, word, lb_sign}.
  - FSM state encoding.
- Sub-module exe_multiplier contains the iterative FSM.
  - Inputs: clk, rst, start, abort, a, b.
  - Outputs: busy, done, product[31:0].
- exe_stage keeps the combinational ALU and bus packing.

Test Plan:
- ADD 0x7FFFFFFF+1, EXE_valid=1 -> same cycle EXE_over=1, exe_result=0x80000000; SUB 0-1 -> 0xFFFFFFFF.
- SRA shamt=4, op2=0x80000000 -> 0xF8000000; SLT -5<3 -> 1; SLTU 0xFFFFFFFB<3 -> 0; LUI op2=0x1234 -> 0x12340000.
- MUL 0x00010003 x 0x00000005, valid at cycle N -> mul_busy cycles N+1..N+32; EXE_over first high at N+33 with result 0x0005000F. Drop valid -> IDLE next cycle.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; MUL 0 x 0x12345678 -> 0.
- rst at BUSY cycle 10 -> next cycle IDLE, mul_busy=0. A fresh MUL 6x7 then completes 33 cycles after start with 0x2A.
- EXE_valid deasserted at BUSY cycle 5 -> IDLE next cycle, EXE_over never asserts. Passthrough pc=0xBFC00010 and rf_wdest=5'd9 appear unchanged on EXE_MEM_bus and EXE_pc.
